// File: rtl/fabric_sram_target.sv
// Single-ported SRAM responder for one fabric slave port: one request in flight, response echoes req_id.
// Define FABRIC_SRAM_TARGET_STATS_EN to build the saturating stat_rd/stat_wr counters (tied to zero otherwise).
module fabric_sram_target #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int ID_W         = 4,
    parameter int ATTR_W       = 8,
    parameter int MEM_BYTES    = 4096,
    parameter int RESP_LATENCY = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic [7:0]          req_op,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [DATA_W-1:0]   req_wdata,
    input  logic [DATA_W/8-1:0] req_wstrb,
    input  logic [2:0]          req_size,
    input  logic [ATTR_W-1:0]   req_attr,
    input  logic [ID_W-1:0]     req_id,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [7:0]          rsp_code,
    output logic [ID_W-1:0]     rsp_id,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic [31:0]         stat_rd,
    output logic [31:0]         stat_wr
);
    localparam logic [7:0] XACT_READ  = 8'h01;
    localparam logic [7:0] XACT_WRITE = 8'h02;
    localparam logic [7:0] RESP_OK    = 8'h00;
    localparam logic [7:0] RESP_FAULT = 8'h01;

    localparam int WORDS = MEM_BYTES / 4;
    localparam int AW    = $clog2(MEM_BYTES);
    localparam int IDX_W = (AW > 2) ? AW - 2 : 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t              state_q;
    logic [3:0]          cnt_q;
    logic                req_ready_q;
    logic                rsp_valid_q;
    logic [7:0]          rsp_code_q;
    logic [ID_W-1:0]     rsp_id_q;
    logic [DATA_W-1:0]   rsp_rdata_q;
    logic [DATA_W-1:0]   mem_q [WORDS];

    logic                is_read;
    logic                is_write;
    logic                out_of_range;
    logic                fault;
    logic                accept;
    logic [IDX_W-1:0]    word_idx;
    logic                attr_unused;

    assign attr_unused  = ^req_attr;
    assign is_read      = (req_op == XACT_READ);
    assign is_write     = (req_op == XACT_WRITE);
    assign out_of_range = ((req_addr >> AW) != '0);
    assign fault        = !(is_read || is_write) || (req_size != 3'd2) ||
                          (req_addr[1:0] != 2'b00) || out_of_range;
    assign accept       = (state_q == S_IDLE) && req_valid && req_ready_q;
    // Truncation of addr>>2 leaves exactly addr[AW-1:2]; upper bits only feed the range check.
    assign word_idx     = IDX_W'(req_addr >> 2);

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_code  = rsp_code_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_rdata = rsp_rdata_q;

    // Array contents survive reset; accept is already forced low while rst is high.
    always_ff @(posedge clk) begin
        if (accept && is_write && !fault) begin
            for (int b = 0; b < DATA_W / 8; b++) begin
                if (req_wstrb[b]) begin
                    mem_q[word_idx][8*b +: 8] <= req_wdata[8*b +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= 4'd0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_code_q  <= 8'h00;
            rsp_id_q    <= '0;
            rsp_rdata_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_q     <= S_WAIT;
                        req_ready_q <= 1'b0;
                        cnt_q       <= 4'(RESP_LATENCY);
                        rsp_id_q    <= req_id;
                        rsp_code_q  <= fault ? RESP_FAULT : RESP_OK;
                        rsp_rdata_q <= (is_read && !fault) ? mem_q[word_idx] : '0;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                S_WAIT: begin
                    if (cnt_q == 4'd0) begin
                        state_q     <= S_RESP;
                        rsp_valid_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                S_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= S_IDLE;
                        rsp_valid_q <= 1'b0;
                        req_ready_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= S_IDLE;
                    req_ready_q <= 1'b0;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef FABRIC_SRAM_TARGET_STATS_EN
    logic [31:0] stat_rd_q;
    logic [31:0] stat_wr_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_q <= 32'h0;
            stat_wr_q <= 32'h0;
        end else if (accept && !fault) begin
            if (is_read && (stat_rd_q != 32'hFFFF_FFFF)) begin
                stat_rd_q <= stat_rd_q + 32'd1;
            end
            if (is_write && (stat_wr_q != 32'hFFFF_FFFF)) begin
                stat_wr_q <= stat_wr_q + 32'd1;
            end
        end
    end

    assign stat_rd = stat_rd_q;
    assign stat_wr = stat_wr_q;
`else
    assign stat_rd = 32'h0;
    assign stat_wr = 32'h0;
`endif

endmodule

// File: tb/tb_fabric_sram_target.sv
// Self-checking bench for fabric_sram_target: directed scenarios plus randomized traffic against a word-array model.
module tb_fabric_sram_target;
    localparam int LAT = 3;
    localparam logic [7:0] OP_RD  = 8'h01;
    localparam logic [7:0] OP_WR  = 8'h02;
    localparam logic [7:0] C_OK   = 8'h00;
    localparam logic [7:0] C_FLT  = 8'h01;
`ifdef FABRIC_SRAM_TARGET_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready;
    logic [7:0]  req_op;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_size;
    logic [7:0]  req_attr;
    logic [3:0]  req_id;
    logic        rsp_valid, rsp_ready;
    logic [7:0]  rsp_code;
    logic [3:0]  rsp_id;
    logic [31:0] rsp_rdata, stat_rd, stat_wr;

    int errors = 0;
    int checks = 0;

    logic [31:0] mem_m [int];
    int exp_rd = 0;
    int exp_wr = 0;

    fabric_sram_target #(.RESP_LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_wstrb(req_wstrb), .req_size(req_size), .req_attr(req_attr),
        .req_id(req_id), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_code(rsp_code),
        .rsp_id(rsp_id), .rsp_rdata(rsp_rdata), .stat_rd(stat_rd), .stat_wr(stat_wr)
    );

    always #5 clk = ~clk;

    // Reference: what the target must answer, and its effect on the array and counters.
    task automatic m_apply(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] st, input logic [2:0] sz,
                           output logic [7:0] ecode, output logic [31:0] erd);
        int k;
        logic [31:0] w;
        k = int'(addr / 4);
        erd = 32'h0;
        if ((op != OP_RD && op != OP_WR) || sz != 3'd2 || (addr % 4) != 0 || addr >= 32'd4096) begin
            ecode = C_FLT;
        end else begin
            ecode = C_OK;
            w = mem_m.exists(k) ? mem_m[k] : 32'h0;
            if (op == OP_RD) begin
                erd = w;
                exp_rd++;
            end else begin
                for (int b = 0; b < 4; b++)
                    if (st[b]) w[8*b +: 8] = wd[8*b +: 8];
                mem_m[k] = w;
                exp_wr++;
            end
        end
    endtask

    // Drives one request and collects its response; lat=-1 if the DUT never answers.
    task automatic xact(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] st, input logic [2:0] sz, input logic [3:0] id,
                        output logic [7:0] code, output logic [3:0] rid, output logic [31:0] rd,
                        output int lat);
        int n;
        code = 8'hEE; rid = 4'h0; rd = 32'h0; lat = -1;
        n = 0;
        while (req_ready !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (req_ready !== 1'b1) return;
        req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wd;
        req_wstrb = st; req_size = sz; req_id = id; req_attr = 8'($urandom);
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin @(posedge clk); #1; n++; end
        if (rsp_valid !== 1'b1) return;
        lat = n; code = rsp_code; rid = rsp_id; rd = rsp_rdata;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready got=%b want=0", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (rsp_code !== 8'h00) begin errors++; $display("FAIL reset_rsp_code got=%h want=00", rsp_code); end
        checks++; if (rsp_id !== 4'h0) begin errors++; $display("FAIL reset_rsp_id got=%h want=0", rsp_id); end
        checks++; if (rsp_rdata !== 32'h0) begin errors++; $display("FAIL reset_rsp_rdata got=%h want=0", rsp_rdata); end
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL post_reset_req_ready got=%b want=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL post_reset_rsp_valid got=%b want=0", rsp_valid); end
        checks++; if (stat_rd !== 32'h0 || stat_wr !== 32'h0) begin
            errors++; $display("FAIL post_reset_stats got=%0d/%0d want=0/0", stat_rd, stat_wr); end
    endtask

    task automatic test_write_read();
        logic [7:0] c; logic [3:0] i; logic [31:0] d; int l;
        logic [7:0] ec; logic [31:0] ed;
        xact(OP_WR, 32'h010, 32'hDEADBEEF, 4'hF, 3'd2, 4'd3, c, i, d, l);
        m_apply(OP_WR, 32'h010, 32'hDEADBEEF, 4'hF, 3'd2, ec, ed);
        checks++; if (c !== C_OK || i !== 4'd3 || d !== 32'h0) begin
            errors++; $display("FAIL wr_rsp got=%h/%h/%h want=%h/3/0", c, i, d, C_OK); end
        checks++; if (l !== LAT + 1) begin errors++; $display("FAIL wr_latency got=%0d want=%0d", l, LAT + 1); end
        xact(OP_RD, 32'h010, 32'h0, 4'h0, 3'd2, 4'd4, c, i, d, l);
        m_apply(OP_RD, 32'h010, 32'h0, 4'h0, 3'd2, ec, ed);
        checks++; if (c !== C_OK || i !== 4'd4 || d !== 32'hDEADBEEF) begin
            errors++; $display("FAIL rd_rsp got=%h/%h/%h want=%h/4/deadbeef", c, i, d, C_OK); end
    endtask

    task automatic test_byte_strobe();
        logic [7:0] c; logic [3:0] i; logic [31:0] d; int l;
        logic [7:0] ec; logic [31:0] ed;
        xact(OP_WR, 32'h020, 32'hAABBCCDD, 4'hF, 3'd2, 4'd1, c, i, d, l);
        m_apply(OP_WR, 32'h020, 32'hAABBCCDD, 4'hF, 3'd2, ec, ed);
        xact(OP_WR, 32'h020, 32'h11223344, 4'h5, 3'd2, 4'd2, c, i, d, l);
        m_apply(OP_WR, 32'h020, 32'h11223344, 4'h5, 3'd2, ec, ed);
        xact(OP_WR, 32'h020, 32'h99999999, 4'h0, 3'd2, 4'd6, c, i, d, l);
        m_apply(OP_WR, 32'h020, 32'h99999999, 4'h0, 3'd2, ec, ed);
        checks++; if (c !== C_OK) begin errors++; $display("FAIL strb0_code got=%h want=%h", c, C_OK); end
        xact(OP_RD, 32'h020, 32'h0, 4'h0, 3'd2, 4'd7, c, i, d, l);
        checks++; if (d !== 32'hAA22CC44 || c !== C_OK || i !== 4'd7) begin
            errors++; $display("FAIL strobe_merge got=%h/%h/%h want=aa22cc44/%h/7", d, c, i, C_OK); end
        m_apply(OP_RD, 32'h020, 32'h0, 4'h0, 3'd2, ec, ed);
    endtask

    task automatic test_faults();
        logic [7:0] c; logic [3:0] i; logic [31:0] d; int l;
        logic [7:0] ops [4]; logic [31:0] adr [4]; logic [2:0] szs [4];
        ops = '{OP_RD, OP_RD, 8'h7F, OP_WR};
        adr = '{32'h1000, 32'h002, 32'h020, 32'h020};
        szs = '{3'd2, 3'd2, 3'd2, 3'd3};
        for (int k = 0; k < 4; k++) begin
            xact(ops[k], adr[k], 32'h0, 4'hF, szs[k], 4'(k + 8), c, i, d, l);
            checks++; if (c !== C_FLT || d !== 32'h0 || i !== 4'(k + 8)) begin
                errors++; $display("FAIL fault_%0d got=%h/%h/%h want=%h/0/%h", k, c, d, i, C_FLT, 4'(k + 8)); end
        end
        xact(OP_RD, 32'h020, 32'h0, 4'h0, 3'd2, 4'd5, c, i, d, l);
        exp_rd++;
        checks++; if (d !== mem_m[8]) begin errors++; $display("FAIL fault_no_write got=%h want=%h", d, mem_m[8]); end
        checks++; if (stat_rd !== (STATS ? 32'(exp_rd) : 32'h0) || stat_wr !== (STATS ? 32'(exp_wr) : 32'h0)) begin
            errors++; $display("FAIL fault_stats got=%0d/%0d want=%0d/%0d", stat_rd, stat_wr,
                               STATS ? exp_rd : 0, STATS ? exp_wr : 0); end
    endtask

    task automatic test_backpressure();
        logic [7:0] ec; logic [31:0] ed; int n;
        req_valid = 1'b1; req_op = OP_WR; req_addr = 32'h008; req_wdata = 32'h0BADF00D;
        req_wstrb = 4'hF; req_size = 3'd2; req_id = 4'd9;
        @(posedge clk); #1;
        req_valid = 1'b0;
        m_apply(OP_WR, 32'h008, 32'h0BADF00D, 4'hF, 3'd2, ec, ed);
        n = 0;
        while (rsp_valid !== 1'b1 && n < 50) begin
            checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_wait_ready got=%b want=0", req_ready); end
            @(posedge clk); #1; n++;
        end
        checks++; if (n !== LAT + 1) begin errors++; $display("FAIL bp_latency got=%0d want=%0d", n, LAT + 1); end
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            checks++; if (rsp_valid !== 1'b1 || rsp_code !== C_OK || rsp_id !== 4'd9 || rsp_rdata !== 32'h0 || req_ready !== 1'b0) begin
                errors++; $display("FAIL bp_hold_%0d got=%b/%h/%h/%h/%b want=1/%h/9/0/0", k, rsp_valid, rsp_code, rsp_id, rsp_rdata, req_ready, C_OK); end
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++; $display("FAIL bp_release got=%b/%b want=0/1", rsp_valid, req_ready); end
    endtask

    task automatic test_random();
        logic [7:0] c; logic [3:0] i; logic [31:0] d; int l;
        logic [7:0] op, ec; logic [31:0] a, wd, ed; logic [3:0] st, id; logic [2:0] sz;
        int r;
        for (int k = 0; k < 16; k++) begin
            wd = $urandom;
            xact(OP_WR, 32'(4 * k), wd, 4'hF, 3'd2, 4'(k), c, i, d, l);
            m_apply(OP_WR, 32'(4 * k), wd, 4'hF, 3'd2, ec, ed);
            checks++; if (c !== ec) begin errors++; $display("FAIL init_%0d got=%h want=%h", k, c, ec); end
        end
        for (int k = 0; k < 80; k++) begin
            r = $urandom_range(0, 9);
            op = ($urandom_range(0, 1) == 0) ? OP_RD : OP_WR;
            a = 32'(4 * $urandom_range(0, 15));
            sz = 3'd2;
            wd = $urandom; st = 4'($urandom); id = 4'($urandom);
            if (r == 0) op = 8'($urandom_range(3, 255));
            if (r == 1) sz = 3'($urandom_range(3, 7));
            if (r == 2) a = a + 32'($urandom_range(1, 3));
            if (r == 3) a = 32'h1000 + 32'(4 * $urandom_range(0, 1000));
            xact(op, a, wd, st, sz, id, c, i, d, l);
            m_apply(op, a, wd, st, sz, ec, ed);
            checks++; if (c !== ec || i !== id || d !== ed || l !== LAT + 1) begin
                errors++; $display("FAIL rand_%0d op=%h a=%h got=%h/%h/%h/%0d want=%h/%h/%h/%0d",
                                   k, op, a, c, i, d, l, ec, id, ed, LAT + 1); end
        end
        checks++; if (stat_rd !== (STATS ? 32'(exp_rd) : 32'h0) || stat_wr !== (STATS ? 32'(exp_wr) : 32'h0)) begin
            errors++; $display("FAIL rand_stats got=%0d/%0d want=%0d/%0d", stat_rd, stat_wr,
                               STATS ? exp_rd : 0, STATS ? exp_wr : 0); end
    endtask

    task automatic test_reset_mid();
        logic [7:0] c; logic [3:0] i; logic [31:0] d; int l;
        logic [7:0] ec; logic [31:0] ed;
        req_valid = 1'b1; req_op = OP_WR; req_addr = 32'h030; req_wdata = 32'h5A5A5A5A;
        req_wstrb = 4'hF; req_size = 3'd2; req_id = 4'd2;
        @(posedge clk); #1;
        req_valid = 1'b0;
        m_apply(OP_WR, 32'h030, 32'h5A5A5A5A, 4'hF, 3'd2, ec, ed);
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 1'b0) begin
            errors++; $display("FAIL midrst_now got=%b/%b want=0/0", rsp_valid, req_ready); end
        exp_rd = 0; exp_wr = 0;
        repeat (LAT + 3) @(posedge clk);
        #1;
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL midrst_hold got=%b want=0", rsp_valid); end
        rst = 1'b0;
        xact(OP_RD, 32'h030, 32'h0, 4'h0, 3'd2, 4'd1, c, i, d, l);
        m_apply(OP_RD, 32'h030, 32'h0, 4'h0, 3'd2, ec, ed);
        checks++; if (c !== C_OK || d !== 32'h5A5A5A5A) begin
            errors++; $display("FAIL midrst_read got=%h/%h want=%h/5a5a5a5a", c, d, C_OK); end
        checks++; if (stat_wr !== 32'h0 || stat_rd !== (STATS ? 32'd1 : 32'd0)) begin
            errors++; $display("FAIL midrst_stats got=%0d/%0d want=0/%0d", stat_wr, stat_rd, STATS ? 1 : 0); end
    endtask

    initial begin
        rst = 1'b1; req_valid = 1'b0; rsp_ready = 1'b0; req_op = 8'h0; req_addr = 32'h0;
        req_wdata = 32'h0; req_wstrb = 4'h0; req_size = 3'd0; req_attr = 8'h0; req_id = 4'h0;
        test_reset();
        test_write_read();
        test_byte_strobe();
        test_faults();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
